reset_sequencer: RTL and testbench

Parametrised reset controller that replaces ad-hoc two-flop reset chains in board top levels. It synchronises the user button and the PLL lock, debounces the button and drives the PLL areset request. Once lock is stable it releases NUM_RST downstream resets in a fixed, staged order (e.g. memory/bus first, CPU last). It handles lock loss, lock timeout with PLL retry, and button re-trigger, and reports status.

---
 rtl/reset_sequencer_if.sv | 29 ++
 rtl/reset_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Board-level reset sequencer pin bundle.
// Ports:
//   btn_n            - asynchronous user button, active low
//   pll_locked       - asynchronous PLL lock indicator
//   pll_areset       - PLL reset request
//   rst_out          - staged active-high resets, bit 0 released first
//   ready            - all staged resets released
//   lock_retry_count - saturating count of lock timeouts plus lock losses
// The slave modport is the sequencer side; master is the board/bench side.
interface reset_sequencer_if #(
    parameter int NUM_RST = 4
);
    logic               btn_n;
    logic               pll_locked;
    logic               pll_areset;
    logic [NUM_RST-1:0] rst_out;
    logic               ready;
    logic [7:0]         lock_retry_count;

    modport master (
        output btn_n, pll_locked,
        input  pll_areset, rst_out, ready, lock_retry_count
    );

    modport slave (
        input  btn_n, pll_locked,
        output pll_areset, rst_out, ready, lock_retry_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises the button and PLL lock, debounces the
// button, drives the PLL reset request and releases NUM_RST downstream
// resets in index order once lock has been stable for HOLD_CYCLES.
// Ports:
//   clk   - system clock, all logic on posedge
//   reset - synchronous active-high reset; restarts the whole sequence
//   bus   - reset_sequencer_if.slave (button/lock in, resets/status out)

// Multi-flop synchroniser for one asynchronous input.
module reset_sequencer_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) sync_q <= {STAGES{RST_VAL}};
        else       sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
endmodule

module reset_sequencer #(
    parameter int NUM_RST         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int PLL_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT    = 1048575,
    parameter int HOLD_CYCLES     = 256,
    parameter int STAGE_GAP       = 16
) (
    input  logic            clk,
    input  logic            reset,
    reset_sequencer_if.slave bus
);
    // One shared counter serves every timed state, so size it for the longest.
    localparam int CMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CMAX_B = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_RST-1:0] ALL_ONES = '1;

    localparam logic [2:0] S_PLLRST   = 3'd0;
    localparam logic [2:0] S_WAITLOCK = 3'd1;
    localparam logic [2:0] S_HOLD     = 3'd2;
    localparam logic [2:0] S_RELEASE  = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;

    // ---------------- synchronisers: [0]=button (idle 1), [1]=lock (idle 0)
    logic [1:0] sync_in, sync_out;
    logic       btn_s, lock_s;

    assign sync_in = {bus.pll_locked, bus.btn_n};

    for (genvar g = 0; g < 2; g++) begin : g_sync
        reset_sequencer_sync #(
            .STAGES  (SYNC_STAGES),
            .RST_VAL (g == 0)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (sync_in[g]),
            .q     (sync_out[g])
        );
    end

    assign btn_s  = sync_out[0];
    assign lock_s = sync_out[1];

    // ---------------- debounce; db_q follows btn_n polarity (1 = released)
    logic          db_q, db_d;
    logic [DW-1:0] dbc_q, dbc_d;
    logic          press_q, press_d;

    always_comb begin
        db_d    = db_q;
        dbc_d   = '0;
        press_d = 1'b0;
        if (btn_s != db_q) begin
            if (dbc_q == DB_LAST) begin
                db_d    = btn_s;
                press_d = db_q;   // only released->pressed is an event
            end else begin
                dbc_d = dbc_q + DW'(1);
            end
        end
    end

    // ---------------- sequencing FSM
    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               glitch_q, glitch_d;
    logic [NUM_RST-1:0] rst_q, rst_d;
    logic               ready_q, ready_d;
    logic               areset_q, areset_d;
    logic [7:0]         retry_q, retry_d;
    logic               bump;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        glitch_d = 1'b0;
        rst_d    = rst_q;
        ready_d  = ready_q;
        retry_d  = retry_q;
        bump     = 1'b0;

        if (press_q) begin
            state_d = S_PLLRST;
            cnt_d   = '0;
            rst_d   = ALL_ONES;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                S_PLLRST: begin
                    if (cnt_q == PLL_LAST) begin
                        state_d = S_WAITLOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAITLOCK: begin
                    if (lock_s) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_PLLRST;
                        cnt_d   = '0;
                        bump    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (!lock_s) begin
                        // A single low sample restarts the hold; two in a
                        // row means lock is really gone.
                        cnt_d = '0;
                        if (glitch_q) state_d = S_WAITLOCK;
                        else          glitch_d = 1'b1;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        rst_d   = ALL_ONES << 1;
                        state_d = S_RELEASE;
                        if (rst_d == '0) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (!lock_s) begin
                        state_d = S_WAITLOCK;
                        cnt_d   = '0;
                        rst_d   = ALL_ONES;
                        ready_d = 1'b0;
                        bump    = 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        // Shifting in zeros keeps the release strictly in
                        // index order.
                        cnt_d = '0;
                        rst_d = rst_q << 1;
                        if (rst_d == '0) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_d = S_WAITLOCK;
                        cnt_d   = '0;
                        rst_d   = ALL_ONES;
                        ready_d = 1'b0;
                        bump    = 1'b1;
                    end
                end
                default: begin
                    state_d = S_PLLRST;
                    cnt_d   = '0;
                    rst_d   = ALL_ONES;
                    ready_d = 1'b0;
                end
            endcase
        end

        if (bump && retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        areset_d = (state_d == S_PLLRST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_q     <= 1'b1;
            dbc_q    <= '0;
            press_q  <= 1'b0;
            state_q  <= S_PLLRST;
            cnt_q    <= '0;
            glitch_q <= 1'b0;
            rst_q    <= ALL_ONES;
            ready_q  <= 1'b0;
            areset_q <= 1'b1;
            retry_q  <= '0;
        end else begin
            db_q     <= db_d;
            dbc_q    <= dbc_d;
            press_q  <= press_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
            rst_q    <= rst_d;
            ready_q  <= ready_d;
            areset_q <= areset_d;
            retry_q  <= retry_d;
        end
    end

    assign bus.pll_areset       = areset_q;
    assign bus.rst_out          = rst_q;
    assign bus.ready            = ready_q;
    assign bus.lock_retry_count = retry_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a time-based reference model predicts the
// registered outputs after every clock edge and queues them; a monitor
// pops one prediction per cycle and compares. Directed timing spot checks
// use constants worked out from the sequencing rules.
module tb_reset_sequencer;
    localparam int NUM_RST         = 3;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 5;
    localparam int PLL_RST_CYCLES  = 4;
    localparam int LOCK_TIMEOUT    = 20;
    localparam int HOLD_CYCLES     = 8;
    localparam int STAGE_GAP       = 3;

    localparam int M_PLLRST = 0, M_WAIT = 1, M_HOLD = 2, M_REL = 3, M_RUN = 4;

    typedef struct packed {
        logic               areset;
        logic [NUM_RST-1:0] rst;
        logic               ready;
        logic [7:0]         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    initial forever #5 clk = ~clk;

    reset_sequencer_if #(.NUM_RST(NUM_RST)) bus();

    reset_sequencer #(
        .NUM_RST         (NUM_RST),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .PLL_RST_CYCLES  (PLL_RST_CYCLES),
        .LOCK_TIMEOUT    (LOCK_TIMEOUT),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STAGE_GAP       (STAGE_GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic void check(string name, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    // ---------------- reference model (phase + entry time, edge-counted)
    exp_t exp_q[$];
    bit   started = 0;
    int   n = 0, t0 = 0, ph = M_PLLRST, retry = 0, run_len = 0;
    bit   db_rel = 1, press_pend = 0, prev_low = 0;
    bit   lq[$], bq[$];

    task automatic model_step(input logic r, input logic b, input logic l);
        int   el;
        bit   lock_s, btn_s, press_now, bump, hold_low;
        exp_t e;
        n++;
        if (r) begin
            started = 1; ph = M_PLLRST; t0 = n; retry = 0;
            db_rel = 1; run_len = 0; press_pend = 0; prev_low = 0;
            lq.delete(); bq.delete();
            for (int s = 0; s < SYNC_STAGES; s++) begin
                lq.push_back(1'b0);
                bq.push_back(1'b1);
            end
        end else if (started) begin
            // inputs reach the logic SYNC_STAGES edges after being sampled
            lock_s = lq.pop_front(); lq.push_back(l);
            btn_s  = bq.pop_front(); bq.push_back(b);
            press_now  = press_pend;
            press_pend = 0;
            if (btn_s != db_rel) begin
                run_len++;
                if (run_len == DEBOUNCE_CYCLES) begin
                    db_rel     = btn_s;
                    run_len    = 0;
                    press_pend = !btn_s;
                end
            end else begin
                run_len = 0;
            end
            el = n - t0; bump = 0; hold_low = 0;
            if (press_now) begin
                ph = M_PLLRST; t0 = n;
            end else begin
                case (ph)
                    M_PLLRST: if (el == PLL_RST_CYCLES) begin ph = M_WAIT; t0 = n; end
                    M_WAIT: begin
                        if (lock_s) begin ph = M_HOLD; t0 = n; end
                        else if (el == LOCK_TIMEOUT) begin ph = M_PLLRST; t0 = n; bump = 1; end
                    end
                    M_HOLD: begin
                        if (!lock_s) begin
                            hold_low = 1; t0 = n;
                            if (prev_low) ph = M_WAIT;
                        end else if (el == HOLD_CYCLES) begin
                            ph = (NUM_RST == 1) ? M_RUN : M_REL; t0 = n;
                        end
                    end
                    M_REL: begin
                        if (!lock_s) begin ph = M_WAIT; t0 = n; bump = 1; end
                        else if (el == (NUM_RST - 1) * STAGE_GAP) ph = M_RUN;
                    end
                    default: if (!lock_s) begin ph = M_WAIT; t0 = n; bump = 1; end
                endcase
            end
            prev_low = hold_low;
            if (bump && retry < 255) retry++;
        end
        if (started) begin
            e.areset = (ph == M_PLLRST);
            e.ready  = (ph == M_RUN);
            e.cnt    = 8'(retry);
            for (int k = 0; k < NUM_RST; k++) begin
                if (ph == M_REL)      e.rst[k] = !((n - t0) >= k * STAGE_GAP);
                else if (ph == M_RUN) e.rst[k] = 1'b0;
                else                  e.rst[k] = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step(reset, bus.btn_n, bus.pll_locked);
    end

    // ---------------- monitor
    initial forever begin
        exp_t e, a;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.pll_areset, bus.rst_out, bus.ready, bus.lock_retry_count};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard: got areset=%b rst=%b ready=%b cnt=%0d, expected areset=%b rst=%b ready=%b cnt=%0d (t=%0t)",
                         a.areset, a.rst, a.ready, a.cnt, e.areset, e.rst, e.ready, e.cnt, $time);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (all called at a negedge)
    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    // Sample index i reflects the state after the i-th edge from now.
    task automatic observe(input int ncyc, input int glitch_at,
                           output int areset_hi, output int rdy_at);
        areset_hi = 0; rdy_at = -1;
        for (int i = 0; i < ncyc; i++) begin
            if (glitch_at >= 0 && i == glitch_at)     bus.pll_locked = 1'b0;
            if (glitch_at >= 0 && i == glitch_at + 1) bus.pll_locked = 1'b1;
            if (bus.pll_areset) areset_hi++;
            if (bus.ready && rdy_at < 0) rdy_at = i;
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(input string name, input int limit);
        int i = 0;
        while (!bus.ready && i < limit) begin
            @(negedge clk);
            i++;
        end
        check({name, " ready within bound"}, int'(bus.ready), 1);
    endtask

    initial begin
        int ah, ra, ah2;
        int i;
        reset = 1'b1;
        bus.btn_n = 1'b1;
        bus.pll_locked = 1'b1;

        // 1: clean bring-up with lock already high
        do_reset();
        check("reset rst_out", int'(bus.rst_out), 7);
        check("reset pll_areset", int'(bus.pll_areset), 1);
        check("reset ready", int'(bus.ready), 0);
        observe(30, -1, ah, ra);
        check("s1 pll_areset cycles", ah, 4);
        check("s1 ready edge", ra, 19);
        check("s1 count", int'(bus.lock_retry_count), 0);

        // 2: lock never comes, PLL retried every 24 cycles
        bus.pll_locked = 1'b0;
        do_reset();
        observe(80, -1, ah, ra);
        check("s2 pll_areset cycles", ah, 16);
        check("s2 count", int'(bus.lock_retry_count), 3);
        check("s2 rst_out", int'(bus.rst_out), 7);
        check("s2 ready", int'(bus.ready), 0);

        // 3: lock arrives, then is lost for 10 cycles in run
        bus.pll_locked = 1'b1;
        wait_ready("s3 first", 200);
        bus.pll_locked = 1'b0;
        observe(10, -1, ah, ra);
        check("s3 no pll_areset", ah, 0);
        check("s3 rst_out", int'(bus.rst_out), 7);
        check("s3 ready", int'(bus.ready), 0);
        check("s3 count", int'(bus.lock_retry_count), 4);
        bus.pll_locked = 1'b1;
        wait_ready("s3 relock", 200);

        // 4: short button bounce ignored, long press restarts
        bus.btn_n = 1'b0;
        observe(3, -1, ah, ra);
        bus.btn_n = 1'b1;
        observe(15, -1, ah, ra);
        check("s4 bounce ignored", int'(bus.ready), 1);
        bus.btn_n = 1'b0;
        observe(10, -1, ah, ra);
        bus.btn_n = 1'b1;
        observe(20, -1, ah2, ra);
        check("s4 press pll_areset cycles", ah + ah2, 4);
        check("s4 count unchanged", int'(bus.lock_retry_count), 4);
        wait_ready("s4 restart", 200);

        // 5: one-cycle lock glitch during hold
        bus.pll_locked = 1'b1;
        do_reset();
        observe(40, 8, ah, ra);
        check("s5 ready edge", ra, 25);

        // random lock/button activity
        for (int s = 0; s < 40; s++) begin
            bus.pll_locked = ($urandom_range(0, 5) != 0);
            bus.btn_n      = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        // 6: saturation, then reset in the middle of the release
        bus.btn_n = 1'b1;
        bus.pll_locked = 1'b0;
        do_reset();
        observe(7300, -1, ah, ra);
        check("s6 count saturates", int'(bus.lock_retry_count), 255);
        bus.pll_locked = 1'b1;
        i = 0;
        while (bus.rst_out != 3'b100 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("s6 reach rst_out=100", int'(bus.rst_out), 4);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("s6 abort rst_out", int'(bus.rst_out), 7);
        check("s6 abort pll_areset", int'(bus.pll_areset), 1);
        check("s6 abort count", int'(bus.lock_retry_count), 0);
        check("s6 abort ready", int'(bus.ready), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
